// File: rtl/gcd_pkg.sv
// Shared types for the subtraction-GCD engine: FSM state encoding and the
// control bundle the FSM drives into the datapath.
package gcd_pkg;
  localparam int GCD_WIDTH_MIN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic load;
    logic sub_x;
    logic sub_y;
  } dp_ctl_t;
endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, the two subtractors and the comparator of the GCD engine.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  dp_ctl_t          ctl,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] x_reg,
  output logic [WIDTH-1:0] y_reg,
  output logic             eq_flg,
  output logic             lt_flg,
  output logic             x_zero,
  output logic             y_zero
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (ctl.load) begin
      x_reg <= x_in;
      y_reg <= y_in;
    end else if (ctl.sub_x) begin
      x_reg <= x_reg - y_reg;
    end else if (ctl.sub_y) begin
      y_reg <= y_reg - x_reg;
    end
  end

  assign eq_flg = (x_reg == y_reg);
  assign lt_flg = (x_reg < y_reg);
  assign x_zero = (x_reg == '0);
  assign y_zero = (y_reg == '0);

endmodule

// File: rtl/gcd_engine.sv
// Euclid-subtraction GCD unit: control FSM and registered outputs around gcd_datapath.
// Define GCD_ITER_CNT_EN to add the iter_cnt subtraction counter port.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             go,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_flg
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [WIDTH-1:0] iter_cnt
`endif
);

  if (WIDTH < GCD_WIDTH_MIN) begin : g_width_chk
    $error("gcd_engine: WIDTH must be at least %0d", GCD_WIDTH_MIN);
  end

  state_t           state;
  dp_ctl_t          ctl;
  logic [WIDTH-1:0] x_reg, y_reg;
  logic             eq_flg, lt_flg, x_zero, y_zero;
  logic             term;

  // Any of the three terminating comparisons ends the computation.
  assign term      = eq_flg | x_zero | y_zero;
  assign ctl.load  = go && (state == IDLE || state == DONE);
  assign ctl.sub_x = (state == TEST) && !term && !lt_flg;
  assign ctl.sub_y = (state == TEST) && !term && lt_flg;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .clr_n  (clr_n),
    .ctl    (ctl),
    .x_in   (x_in),
    .y_in   (y_in),
    .x_reg  (x_reg),
    .y_reg  (y_reg),
    .eq_flg (eq_flg),
    .lt_flg (lt_flg),
    .x_zero (x_zero),
    .y_zero (y_zero)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      zero_flg <= 1'b0;
      gcd_out  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state    <= TEST;
            busy     <= 1'b1;
            done     <= 1'b0;
            zero_flg <= 1'b0;
          end
        end
        TEST: begin
          if (term) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            // eq with x==0 means both operands were zero
            zero_flg <= eq_flg & x_zero;
            gcd_out  <= (x_zero && !eq_flg) ? y_reg : x_reg;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GCD_ITER_CNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                        iter_cnt <= '0;
    else if (ctl.load)                 iter_cnt <= '0;
    else if (ctl.sub_x || ctl.sub_y)   iter_cnt <= iter_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/gcd_engine.md
# gcd_engine

- Parametrised Euclid-subtraction GCD unit: control FSM plus datapath in one block.
- Operands are captured on a `go` request. The unit iterates one subtraction per clock and holds the result with a level `done` flag until the next request.
- Successor to the fixed-width GCD control unit: adds a width parameter, a busy/done handshake, zero-operand handling, and an optional iteration counter.
- Sits between operand registers (or a bus slave) and any consumer of the result.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `clr_n` in 1: reset, asynchronous, active-low.
- `go` in 1: start request; sampled only in IDLE or DONE.
- `x_in` in WIDTH: operand X, sampled on the accepting edge.
- `y_in` in WIDTH: operand Y, sampled on the accepting edge.
- `busy` out 1: high while in TEST.
- `done` out 1: high in DONE; `gcd_out` is valid while high.
- `gcd_out` out WIDTH: result, registered.
- `zero_flg` out 1: set in DONE when both operands were 0.
- `iter_cnt` out WIDTH: subtraction count; present only with `GCD_ITER_CNT_EN`.

## Operation
- States: IDLE, TEST, DONE. An encoding for a fourth state is not used and recovers to IDLE.
- Reset (`clr_n`=0, asynchronous):
  - state goes to IDLE;
  - x_reg, y_reg, `gcd_out`, `iter_cnt` go to 0;
  - `busy`, `done`, `zero_flg` go to 0;
  - mid-computation reset abandons the operation, with no partial result.
- IDLE or DONE with `go`=1:
  - x_reg←`x_in`, y_reg←`y_in`, `iter_cnt`←0, `done`←0, `zero_flg`←0;
  - state→TEST.
- DONE with `go`=0: hold all outputs.
- TEST, one action per cycle, in priority order:
  - x_reg==y_reg: `gcd_out`←x_reg, →DONE. When both are 0, also `zero_flg`←1 and `gcd_out`=0.
  - x_reg==0: `gcd_out`←y_reg, →DONE.
  - y_reg==0: `gcd_out`←x_reg, →DONE.
  - x_reg<y_reg (unsigned): y_reg←y_reg−x_reg, `iter_cnt`+1, stay in TEST.
  - otherwise: x_reg←x_reg−y_reg, `iter_cnt`+1, stay in TEST.
- `go` during TEST is ignored; `x_in`/`y_in` are not re-sampled.
- Arithmetic is unsigned WIDTH-bit. The subtraction never underflows, because the smaller value is always subtracted from the larger.
- Worst-case subtraction count is 2^WIDTH−2 (operands 2^WIDTH−1 and 1), so `iter_cnt` never wraps.

## Timing
- Call the accepting edge E0, and let s be the number of subtractions.
- `busy` rises after E0.
- Subtractions occur on edges E1..Es.
- The terminating comparison occurs on edge E(s+1). After that edge, `done`=1, `busy`=0, and `gcd_out` is valid.
- Total latency from accept to `done` is s+1 cycles; equal or zero operands give 1 cycle.
- `done` and `gcd_out` persist in DONE indefinitely.
- A `go` in DONE clears `done` on the next edge (back-to-back operation, no idle cycle needed).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `GCD_ITER_CNT_EN`.
- Defined:
  - the `iter_cnt` port and counter register exist;
  - the counter is cleared on accept, incremented per subtraction, and frozen in DONE.
- Undefined:
  - the port and register are absent;
  - all other behaviour and timing are identical.

## Structure
- `gcd_pkg`: the `state_t` enum (IDLE, TEST, DONE) and a `GCD_WIDTH_MIN`=2 constant, checked with an elaboration-time assertion.
- Sub-module `gcd_datapath #(WIDTH)` contains:
  - x_reg, y_reg, the two subtractors, and the comparator;
  - outputs `eq_flg`, `lt_flg`, `x_zero`, `y_zero`;
  - load/select inputs driven by the FSM in `gcd_engine`.
- The FSM and output registers stay in `gcd_engine`.

## Test plan
- WIDTH=8, x=12, y=8, `go` pulse → `busy` for 3 cycles; `done` 3 cycles after accept; `gcd_out`=4; `iter_cnt`=2.
- x=13, y=13 → `done` 1 cycle after accept; `gcd_out`=13; `iter_cnt`=0.
- x=0, y=9 → `gcd_out`=9, `zero_flg`=0. Then x=0, y=0 → `gcd_out`=0, `zero_flg`=1.
- x=255, y=1 → `gcd_out`=1; `iter_cnt`=254; `done` 255 cycles after accept.
- Start x=48, y=18; during TEST hold `go`=1 with x_in=7 → inputs ignored, `gcd_out`=6. Then `go` in DONE with x=21, y=14 → `done` drops next cycle, result 7.
- x=200, y=3 started; deassert `clr_n` mid-TEST (asynchronously, between edges) → all outputs 0 immediately. After release, a new x=10, y=4 gives 2.
